// File: rtl/simple_pkg.sv
// Shared definitions for the phase sequencer: state encoding, default
// parameters and a width helper that stays legal for degenerate sizes.
package simple_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_t;

    localparam int DEF_NUM_PHASES      = 5;
    localparam int DEF_PHASE_WIDTH     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_COUNT_WIDTH     = 16;

    // Counter width that never collapses to zero bits (n==1 still needs a flop).
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Button/halt inputs and phase/status outputs of the phase sequencer.
// master = board/CPU side, slave = the sequencer itself.
interface phase_sequencer_if
    import simple_pkg::*;
#(
    parameter int NUM_PHASES  = DEF_NUM_PHASES,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) ();
    localparam int IDX_W = $clog2(NUM_PHASES);

    logic                   execbutton;
    logic                   stepbutton;
    logic                   haltin;
    logic [NUM_PHASES-1:0]  phase;
    logic [IDX_W-1:0]       phase_index;
    logic                   instr_done;
    logic                   running;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] instr_count;

    modport master (
        output execbutton, stepbutton, haltin,
        input  phase, phase_index, instr_done, running, halted, instr_count
    );

    modport slave (
        input  execbutton, stepbutton, haltin,
        output phase, phase_index, instr_done, running, halted, instr_count
    );

endinterface

// File: rtl/button_debounce.sv
// Synchronises a raw button, accepts a new level only after it has been
// stable for DEBOUNCE_CYCLES samples, and pulses once on each accepted press.
module button_debounce
    import simple_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic pulse
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          level_next;
    logic          pulse_reg;
    logic          pulse_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // The counter tracks consecutive samples disagreeing with the accepted
    // level; any agreeing sample restarts the count.
    always_comb begin
        level_next = level_reg;
        pulse_next = 1'b0;
        cnt_next   = '0;
        if (sync2_reg != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = sync2_reg;
                pulse_next = sync2_reg;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            pulse_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= button;
            sync2_reg <= sync1_reg;
            level_reg <= level_next;
            pulse_reg <= pulse_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase instruction sequencer: run / single-step / halt control with
// debounced buttons, registered one-hot phase pulses and a retired counter.
module phase_sequencer
    import simple_pkg::*;
#(
    parameter int NUM_PHASES      = DEF_NUM_PHASES,
    parameter int PHASE_WIDTH     = DEF_PHASE_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    phase_sequencer_if.slave   bus
);
    localparam int            PW     = $clog2(NUM_PHASES);
    localparam int            SW     = safe_clog2(PHASE_WIDTH);
    localparam logic [PW-1:0] P_LAST = PW'(NUM_PHASES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(PHASE_WIDTH - 1);

    logic [1:0] raw_buttons;
    logic [1:0] button_pulses;
    logic       run_pulse;
    logic       step_pulse;

    assign raw_buttons = {bus.stepbutton, bus.execbutton};
    assign run_pulse   = button_pulses[0];
    assign step_pulse  = button_pulses[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_button
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock (clock),
                .reset (reset),
                .button(raw_buttons[gi]),
                .pulse (button_pulses[gi])
            );
        end
    endgenerate

    seq_state_t             state_reg, state_next;
    logic [PW-1:0]          p_reg, p_next;
    logic [SW-1:0]          s_reg, s_next;
    logic                   halt_pending_reg, halt_pending_next;
    logic                   pause_pending_reg, pause_pending_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic [NUM_PHASES-1:0]  phase_reg, phase_next;
    logic                   instr_done_reg, instr_done_next;
    logic                   running_reg, running_next;
    logic                   halted_reg, halted_next;
    logic                   active;
    logic                   at_boundary;
    logic                   active_next;

    assign active      = (state_reg == ST_RUN) || (state_reg == ST_STEP);
    assign at_boundary = active && (p_reg == P_LAST) && (s_reg == S_LAST);

    always_comb begin
        state_next         = state_reg;
        p_next             = p_reg;
        s_next             = s_reg;
        halt_pending_next  = halt_pending_reg | bus.haltin;
        pause_pending_next = pause_pending_reg;
        count_next         = count_reg;

        // Slot advance; the wrap at the boundary already leaves p=0,s=0 for
        // whichever state follows.
        if (active) begin
            if (s_reg == S_LAST) begin
                s_next = '0;
                p_next = (p_reg == P_LAST) ? '0 : p_reg + PW'(1);
            end else begin
                s_next = s_reg + SW'(1);
            end
        end

        if (at_boundary) begin
            count_next = count_reg + COUNT_WIDTH'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                pause_pending_next = 1'b0;
                p_next             = '0;
                s_next             = '0;
                if (halt_pending_reg) begin
                    state_next = ST_HALTED;
                end else if (run_pulse) begin
                    state_next = ST_RUN;
                end else if (step_pulse) begin
                    state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                if (run_pulse) begin
                    pause_pending_next = 1'b1;
                end
                if (at_boundary) begin
                    if (halt_pending_reg) begin
                        state_next = ST_HALTED;
                    end else if (pause_pending_reg) begin
                        state_next         = ST_IDLE;
                        pause_pending_next = 1'b0;
                    end
                end
            end
            ST_STEP: begin
                if (at_boundary) begin
                    state_next = halt_pending_reg ? ST_HALTED : ST_IDLE;
                end
            end
            ST_HALTED: begin
                p_next = '0;
                s_next = '0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered values line
    // up with the p/s registers in the same cycle.
    always_comb begin
        active_next     = (state_next == ST_RUN) || (state_next == ST_STEP);
        running_next    = active_next;
        halted_next     = (state_next == ST_HALTED);
        instr_done_next = active_next && (p_next == P_LAST) && (s_next == S_LAST);
    end

    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
            assign phase_next[gi] = active_next && (s_next == '0) && (p_next == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            p_reg             <= '0;
            s_reg             <= '0;
            halt_pending_reg  <= 1'b0;
            pause_pending_reg <= 1'b0;
            count_reg         <= '0;
            phase_reg         <= '0;
            instr_done_reg    <= 1'b0;
            running_reg       <= 1'b0;
            halted_reg        <= 1'b0;
        end else begin
            state_reg         <= state_next;
            p_reg             <= p_next;
            s_reg             <= s_next;
            halt_pending_reg  <= halt_pending_next;
            pause_pending_reg <= pause_pending_next;
            count_reg         <= count_next;
            phase_reg         <= phase_next;
            instr_done_reg    <= instr_done_next;
            running_reg       <= running_next;
            halted_reg        <= halted_next;
        end
    end

    assign bus.phase       = phase_reg;
    assign bus.phase_index = p_reg;
    assign bus.instr_done  = instr_done_reg;
    assign bus.running     = running_reg;
    assign bus.halted      = halted_reg;
    assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench: instance A uses default parameters, instance B uses
// COUNT_WIDTH=4 and long phase slots for wrap, pause and step-in-step cases.
module tb_phase_sequencer;
    import simple_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    phase_sequencer_if #(.NUM_PHASES(5), .COUNT_WIDTH(16)) a_if ();
    phase_sequencer_if #(.NUM_PHASES(5), .COUNT_WIDTH(4))  b_if ();

    phase_sequencer #(
        .NUM_PHASES(5), .PHASE_WIDTH(2), .DEBOUNCE_CYCLES(16), .COUNT_WIDTH(16)
    ) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (a_if.slave)
    );

    phase_sequencer #(
        .NUM_PHASES(5), .PHASE_WIDTH(10), .DEBOUNCE_CYCLES(16), .COUNT_WIDTH(4)
    ) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (b_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [4:0]  ph_log   [0:127];
    logic        done_log [0:127];
    logic        run_log  [0:127];
    logic        halt_log [0:127];
    logic [15:0] cnt_log  [0:127];
    int first_p0;
    int halt_cyc;
    int pulse_total;
    int done_total;

    // Runs instance A for n cycles, logging outputs and applying button edges
    // at the given cycle numbers (-1 = never); optionally fires a one-cycle
    // haltin in the first cycle where phase[2] is high.
    task automatic run_a(input int n, input int ex_on, input int ex_off,
                         input int st_on, input int st_off, input bit halt_p2);
        first_p0    = -1;
        halt_cyc    = -1;
        pulse_total = 0;
        done_total  = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            ph_log[k]   = a_if.phase;
            done_log[k] = a_if.instr_done;
            run_log[k]  = a_if.running;
            halt_log[k] = a_if.halted;
            cnt_log[k]  = a_if.instr_count;
            if (a_if.phase != 5'd0) pulse_total++;
            if (a_if.instr_done) done_total++;
            if (first_p0 < 0 && a_if.phase == 5'd1) first_p0 = k;
            if (k == ex_on)  a_if.execbutton = 1'b1;
            if (k == ex_off) a_if.execbutton = 1'b0;
            if (k == st_on)  a_if.stepbutton = 1'b1;
            if (k == st_off) a_if.stepbutton = 1'b0;
            a_if.haltin = 1'b0;
            if (halt_p2 && halt_cyc < 0 && a_if.phase[2]) begin
                a_if.haltin = 1'b1;
                halt_cyc    = k;
            end
        end
        a_if.haltin = 1'b0;
    endtask

    logic [4:0] exp_ph;
    int dn, pause_at, cyc, exp_cnt, b_pulses, b_dones;
    bit chk_next, prev_run, prev_done, paused;

    initial begin
        a_if.execbutton = 1'b0; a_if.stepbutton = 1'b0; a_if.haltin = 1'b0;
        b_if.execbutton = 1'b0; b_if.stepbutton = 1'b0; b_if.haltin = 1'b0;

        // Reset state
        @(posedge clock); @(posedge clock); #1;
        check_eq("rst_phase", a_if.phase, 0);
        check_eq("rst_running", a_if.running, 0);
        check_eq("rst_halted", a_if.halted, 0);
        check_eq("rst_count", a_if.instr_count, 0);
        check_eq("rst_done", a_if.instr_done, 0);
        check_eq("rst_b_phase", b_if.phase, 0);
        @(negedge clock); reset = 1'b0;
        $display("[reset] released");

        // Exec press: phase timing of the first instruction
        run_a(60, 0, 20, -1, -1, 1'b0);
        $display("[run] entry at cycle %0d, %0d instructions done", first_p0, done_total);
        check_eq("run_start", (first_p0 >= 0 && first_p0 <= 49), 1);
        if (first_p0 >= 0 && first_p0 <= 49) begin
            for (int o = 0; o <= 10; o++) begin
                if (o == 10)          exp_ph = 5'd1;
                else if (o % 2 == 0)  exp_ph = 5'(1 << (o / 2));
                else                  exp_ph = 5'd0;
                check_eq($sformatf("run_phase_o%0d", o), ph_log[first_p0 + o], exp_ph);
                check_eq($sformatf("run_done_o%0d", o), done_log[first_p0 + o], (o == 9) ? 1 : 0);
            end
            check_eq("run_running", run_log[first_p0], 1);
            check_eq("run_count_o10", cnt_log[first_p0 + 10], 1);
        end
        check_eq("run_count_model", a_if.instr_count, done_total - int'(done_log[59]));

        // Reset asserted mid-instruction
        for (int i = 0; i < 10 && a_if.phase == 5'd0; i++) begin
            @(posedge clock); #1;
        end
        check_eq("midrst_pre_phase", a_if.phase != 5'd0, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_phase", a_if.phase, 0);
        check_eq("midrst_running", a_if.running, 0);
        check_eq("midrst_count", a_if.instr_count, 0);
        @(posedge clock); @(negedge clock); reset = 1'b0;
        run_a(40, -1, -1, -1, -1, 1'b0);
        $display("[midrst] idle pulses after release: %0d", pulse_total);
        check_eq("midrst_idle_pulses", pulse_total, 0);
        check_eq("midrst_idle_running", run_log[39], 0);

        // Step press, exec pressed so its pulse lands inside STEP
        run_a(80, 5, 25, 0, 20, 1'b0);
        $display("[step] entry at cycle %0d, pulses %0d", first_p0, pulse_total);
        check_eq("step_pulses", pulse_total, 5);
        check_eq("step_dones", done_total, 1);
        check_eq("step_start", (first_p0 >= 0 && first_p0 <= 69), 1);
        if (first_p0 >= 0 && first_p0 <= 69) begin
            check_eq("step_done_o9", done_log[first_p0 + 9], 1);
            check_eq("step_phase4_o8", ph_log[first_p0 + 8], 5'd16);
            check_eq("step_running_o10", run_log[first_p0 + 10], 0);
        end
        check_eq("step_count", cnt_log[79], 1);
        check_eq("step_idle_end", run_log[79], 0);

        // Exec glitch shorter than the debounce window, then a clean press
        run_a(50, 0, 10, -1, -1, 1'b0);
        $display("[glitch] pulses %0d", pulse_total);
        check_eq("glitch_pulses", pulse_total, 0);
        check_eq("glitch_running", run_log[49], 0);
        run_a(60, 0, 20, -1, -1, 1'b0);
        $display("[clean] entry at cycle %0d, running %0d", first_p0, run_log[59]);
        check_eq("clean_start", first_p0 >= 0, 1);
        check_eq("clean_still_running", run_log[59], 1);

        // Halt request while p=2
        run_a(40, -1, -1, -1, -1, 1'b1);
        $display("[halt] haltin at cycle %0d", halt_cyc);
        check_eq("halt_seen", (halt_cyc >= 0 && halt_cyc <= 33), 1);
        if (halt_cyc >= 0 && halt_cyc <= 33) begin
            check_eq("halt_phase3", ph_log[halt_cyc + 2], 5'd8);
            check_eq("halt_phase4", ph_log[halt_cyc + 4], 5'd16);
            check_eq("halt_done", done_log[halt_cyc + 5], 1);
            check_eq("halt_not_early", halt_log[halt_cyc + 5], 0);
            check_eq("halt_halted", halt_log[halt_cyc + 6], 1);
            check_eq("halt_phase0", ph_log[halt_cyc + 6], 0);
            check_eq("halt_running", run_log[halt_cyc + 6], 0);
        end
        run_a(60, 0, 20, 5, 25, 1'b0);
        $display("[halt] pulses after button presses %0d", pulse_total);
        check_eq("halted_pulses", pulse_total, 0);
        check_eq("halted_sticky", halt_log[59], 1);
        @(posedge clock); #2 reset = 1'b1;
        #1;
        check_eq("halt_cleared_by_reset", a_if.halted, 0);
        @(posedge clock); @(negedge clock); reset = 1'b0;

        // Instance B: counter wrap over 17 instructions, then pause
        dn = 0; pause_at = -1; chk_next = 1'b0; prev_run = 1'b0; prev_done = 1'b0;
        paused = 1'b0; exp_cnt = 0; cyc = 0;
        b_if.execbutton = 1'b1;
        while (!paused && cyc < 1500) begin
            @(posedge clock); #1;
            if (cyc == 20) b_if.execbutton = 1'b0;
            if (chk_next) begin
                check_eq($sformatf("wrap_count_after_%0d", dn), b_if.instr_count, exp_cnt);
                chk_next = 1'b0;
                if (dn == 17) begin
                    pause_at = cyc;
                    b_if.execbutton = 1'b1;
                end
            end
            if (pause_at >= 0 && cyc == pause_at + 20) b_if.execbutton = 1'b0;
            if (pause_at >= 0 && prev_run && !b_if.running) begin
                check_eq("pause_after_done", prev_done, 1);
                check_eq("pause_phase", b_if.phase, 0);
                paused = 1'b1;
            end
            if (b_if.instr_done) begin
                dn++;
                if (dn == 16 || dn == 17) begin
                    chk_next = 1'b1;
                    exp_cnt  = (dn == 16) ? 0 : 1;
                end
            end
            prev_run  = b_if.running;
            prev_done = b_if.instr_done;
            cyc++;
        end
        $display("[wrap] %0d instructions, paused=%0d at cycle %0d", dn, paused, cyc);
        check_eq("pause_reached", paused, 1);
        check_eq("pause_instr_total", dn, 18);
        check_eq("pause_count", b_if.instr_count, 2);

        // Instance B: second step press lands inside a long STEP
        b_pulses = 0; b_dones = 0;
        for (int k = 0; k < 160; k++) begin
            @(posedge clock); #1;
            if (b_if.phase != 5'd0) b_pulses++;
            if (b_if.instr_done) b_dones++;
            if (k == 0)  b_if.stepbutton = 1'b1;
            if (k == 20) b_if.stepbutton = 1'b0;
            if (k == 42) b_if.stepbutton = 1'b1;
            if (k == 62) b_if.stepbutton = 1'b0;
        end
        $display("[step2] pulses %0d, instructions %0d", b_pulses, b_dones);
        check_eq("step2_pulses", b_pulses, 5);
        check_eq("step2_dones", b_dones, 1);
        check_eq("step2_count", b_if.instr_count, 3);
        check_eq("step2_running", b_if.running, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
